// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a valid/ready FIFO feeds an LSB-first serialiser with
// optional parity, 1 or 2 stop bits, break generation and a self-timed bit clock.
module uart_tx_buffered #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int CLK_DIV     = 434,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_MODE = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            s_valid,
  input  logic [DATA_WIDTH-1:0]           s_data,
  output logic                            s_ready,
  input  logic                            break_req,
  output logic                            tx,
  output logic                            tx_busy,
  output logic                            frame_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  stop_q, stop_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  guard_q, guard_d;
  logic                  tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic                  push, pop, empty, bit_end, start_frame, head_par;
  logic [DATA_WIDTH-1:0] head;

  assign s_ready  = (level_q != LW'(FIFO_DEPTH));
  assign push     = s_valid && s_ready;
  assign empty    = (level_q == '0);
  assign bit_end  = (cnt_q == '0);
  assign head     = mem_q[rd_ptr_q];
  assign head_par = (PARITY_MODE == 2) ? ~^head : ^head;

  // Pointers are exactly AW bits wide, so they wrap modulo the power-of-two depth.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(push) - LW'(pop);
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch can be inferred.
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    stop_d      = stop_q;
    shift_d     = shift_q;
    par_d       = par_q;
    guard_d     = guard_q;
    tx_d        = tx_q;
    start_frame = 1'b0;
    if (state_q != S_IDLE) cnt_d = bit_end ? BIT_LAST : cnt_q - CW'(1);
    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (break_req) begin
          tx_d    = 1'b0;
          guard_d = 1'b1;
          cnt_d   = BIT_LAST;
        end else if (guard_q) begin
          // After a break the line must idle high for one full bit before a start bit.
          if (bit_end) guard_d = 1'b0;
          else         cnt_d   = cnt_q - CW'(1);
        end else if (!empty) begin
          start_frame = 1'b1;
        end
      end
      S_START: if (bit_end) begin
        state_d = S_DATA;
        tx_d    = shift_q[0];
      end
      S_DATA: if (bit_end) begin
        if (bit_q == BW'(DATA_WIDTH - 1)) begin
          if (PARITY_MODE != 0) begin
            state_d = S_PARITY;
            tx_d    = par_q;
          end else begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end
        end else begin
          bit_d   = bit_q + BW'(1);
          shift_d = shift_q >> 1;
          tx_d    = shift_q[1];
        end
      end
      S_PARITY: if (bit_end) begin
        state_d = S_STOP;
        tx_d    = 1'b1;
      end
      S_STOP: if (bit_end) begin
        if (stop_q == STOP_LAST) begin
          if (!empty && !break_req) start_frame = 1'b1;
          else                      state_d     = S_IDLE;
        end else begin
          stop_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (start_frame) begin
      state_d = S_START;
      shift_d = head;
      par_d   = head_par;
      bit_d   = '0;
      stop_d  = 1'b0;
      cnt_d   = BIT_LAST;
      tx_d    = 1'b0;
    end
  end

  assign pop = start_frame;
  // Registered one cycle early so the pulse lands on the last clk of the final stop bit.
  assign done_d = (state_q == S_STOP) && (stop_q == STOP_LAST) && (cnt_q == CW'(1));
  assign busy_d = (state_d != S_IDLE);

  // NOTE: the storage array has no reset; only pointers and level define its contents.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= S_IDLE;
      cnt_q    <= BIT_LAST;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      guard_q  <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      guard_q  <= guard_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tx         = tx_q;
  assign tx_busy    = busy_q;
  assign frame_done = done_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: three instances (no parity / even+2 stop /
// odd parity); stimulus queues expected frames, per-instance monitors decode the line.
module tb_uart_tx_buffered;

  localparam int CLK_DIV = 4;
  localparam int DW      = 8;
  localparam int DEPTH   = 16;
  localparam int LW      = $clog2(DEPTH + 1);
  localparam int N       = 3;
  localparam int FRAME0  = CLK_DIV * (1 + DW + 1);

  typedef struct {
    logic [DW-1:0] data;
    logic          par;
    int            start_cyc;  // -1: don't care
    int            gap;        // idle-high clks before start, -1: don't care
    int            lvl;        // fifo_level on last frame clk, -1: don't care
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid    [N];
  logic [DW-1:0] s_data     [N];
  logic          break_req  [N];
  logic          s_ready    [N];
  logic          tx         [N];
  logic          tx_busy    [N];
  logic          frame_done [N];
  logic [LW-1:0] fifo_level [N];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_buffered #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CLK_DIV(CLK_DIV),
                     .STOP_BITS(1), .PARITY_MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid[0]), .s_data(s_data[0]), .s_ready(s_ready[0]),
    .break_req(break_req[0]), .tx(tx[0]), .tx_busy(tx_busy[0]), .frame_done(frame_done[0]),
    .fifo_level(fifo_level[0]));

  uart_tx_buffered #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CLK_DIV(CLK_DIV),
                     .STOP_BITS(2), .PARITY_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid[1]), .s_data(s_data[1]), .s_ready(s_ready[1]),
    .break_req(break_req[1]), .tx(tx[1]), .tx_busy(tx_busy[1]), .frame_done(frame_done[1]),
    .fifo_level(fifo_level[1]));

  uart_tx_buffered #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .CLK_DIV(CLK_DIV),
                     .STOP_BITS(1), .PARITY_MODE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid[2]), .s_data(s_data[2]), .s_ready(s_ready[2]),
    .break_req(break_req[2]), .tx(tx[2]), .tx_busy(tx_busy[2]), .frame_done(frame_done[2]),
    .fifo_level(fifo_level[2]));

  function automatic int pm_of(input int g);
    return (g == 1) ? 1 : (g == 2) ? 2 : 0;
  endfunction

  function automatic int sb_of(input int g);
    return (g == 1) ? 2 : 1;
  endfunction

  function automatic void sb_push(input int g, input exp_t e);
    case (g)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  function automatic int sb_size(input int g);
    return (g == 0) ? q0.size() : (g == 1) ? q1.size() : q2.size();
  endfunction

  function automatic void sb_pop(input int g, output exp_t e);
    case (g)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Called on a negedge; the word is presented for exactly one rising edge.
  task automatic push(input int g, input logic [DW-1:0] d, input logic par, input bit exp_rdy,
                      input int start, input int gap, input int lvl);
    exp_t e;
    s_valid[g] = 1'b1;
    s_data[g]  = d;
    check($sformatf("dut%0d s_ready before push %0h", g, d), s_ready[g], exp_rdy);
    if (exp_rdy) begin
      e.data = d; e.par = par; e.start_cyc = start; e.gap = gap; e.lvl = lvl;
      sb_push(g, e);
    end
    @(posedge clk);
    @(negedge clk);
    s_valid[g] = 1'b0;
  endtask

  task automatic wait_drain(input int g, input int budget);
    int n;
    n = 0;
    while ((sb_size(g) != 0 || tx_busy[g]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) check($sformatf("dut%0d drain timeout, words left", g), sb_size(g), 0);
  endtask

  // Entered on the negedge of the first start-bit clk; samples every clk of the frame.
  task automatic rx_frame(input int g, input int idle);
    int            nbits, sb, start_cyc;
    logic [15:0]   bits;
    bit            shape_ok, done_ok;
    logic [LW-1:0] lvl_end;
    exp_t          e;
    sb        = sb_of(g);
    nbits     = 1 + DW + ((pm_of(g) != 0) ? 1 : 0) + sb;
    start_cyc = cyc;
    shape_ok  = 1'b1;
    done_ok   = 1'b1;
    bits      = '0;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < CLK_DIV; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (!rst_n) return;
        if (c == 0) bits[b] = tx[g];
        else if (tx[g] !== bits[b]) shape_ok = 1'b0;
        if (tx_busy[g] !== 1'b1) shape_ok = 1'b0;
        if (frame_done[g] !== ((b == nbits - 1) && (c == CLK_DIV - 1))) done_ok = 1'b0;
      end
    end
    lvl_end = fifo_level[g];
    if (bits[0] !== 1'b0) shape_ok = 1'b0;
    for (int b = nbits - sb; b < nbits; b++) if (bits[b] !== 1'b1) shape_ok = 1'b0;
    if (sb_size(g) == 0) begin
      n_checks++;
      $display("FAIL dut%0d unexpected frame: got data 0x%0h, want no frame", g, bits[DW:1]);
      return;
    end
    sb_pop(g, e);
    check($sformatf("dut%0d frame shape %0h", g, e.data), shape_ok, 1);
    check($sformatf("dut%0d data", g), bits[DW:1], e.data);
    if (pm_of(g) != 0) check($sformatf("dut%0d parity %0h", g, e.data), bits[DW+1], e.par);
    check($sformatf("dut%0d frame_done %0h", g, e.data), done_ok, 1);
    if (e.start_cyc >= 0) check($sformatf("dut%0d start clk %0h", g, e.data), start_cyc, e.start_cyc);
    if (e.gap >= 0) check($sformatf("dut%0d idle gap %0h", g, e.data), idle, e.gap);
    if (e.lvl >= 0) check($sformatf("dut%0d level at end %0h", g, e.data), lvl_end, e.lvl);
  endtask

  for (genvar g = 0; g < N; g++) begin : g_mon
    initial begin
      int idle;
      idle = 0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          idle = 0;
        end else if (tx_busy[g] && !tx[g]) begin
          rx_frame(g, idle);
          idle = 0;
        end else begin
          if (frame_done[g]) check($sformatf("dut%0d stray frame_done", g), frame_done[g], 0);
          idle = tx[g] ? idle + 1 : 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global timeout at clk %0d", cyc);
    $fatal(1);
  end

  initial begin
    int   n0, e_edge, pulses;
    exp_t e;
    for (int g = 0; g < N; g++) begin
      s_valid[g] = 1'b0; s_data[g] = '0; break_req[g] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < N; g++) begin
      check($sformatf("dut%0d reset tx", g), tx[g], 1);
      check($sformatf("dut%0d reset tx_busy", g), tx_busy[g], 0);
      check($sformatf("dut%0d reset frame_done", g), frame_done[g], 0);
      check($sformatf("dut%0d reset fifo_level", g), fifo_level[g], 0);
      check($sformatf("dut%0d reset s_ready", g), s_ready[g], 1);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frame 0x55: start at accept edge + 1, 40 clks, frame_done on the last clk.
    push(0, 8'h55, 1'b0, 1'b1, cyc + 2, -1, 0);
    wait_drain(0, 100);

    // 0x07 has three ones: even parity bit 1 (two stop bits), odd parity bit 0.
    fork
      push(1, 8'h07, 1'b1, 1'b1, cyc + 2, -1, 0);
      push(2, 8'h07, 1'b0, 1'b1, cyc + 2, -1, 0);
    join
    wait_drain(1, 120);
    wait_drain(2, 120);

    // Burst of three: no idle clk between frames, level 2 -> 1 -> 0 at frame ends.
    push(0, 8'hA1, 1'b0, 1'b1, cyc + 2, -1, 2);
    push(0, 8'hB2, 1'b0, 1'b1, -1, 0, 1);
    push(0, 8'hC3, 1'b0, 1'b1, -1, 0, 0);
    wait_drain(0, 3 * FRAME0 + 20);

    // Break held while the FIFO is overfilled; the two extra writes must be dropped.
    break_req[0] = 1'b1;
    repeat (2) @(negedge clk);
    check("dut0 tx low during break", tx[0], 0);
    check("dut0 tx_busy during break", tx_busy[0], 0);
    for (int i = 0; i < DEPTH + 2; i++)
      push(0, 8'(8'h20 + i), 1'b0, (i < DEPTH), -1, (i == 0) ? -1 : 0, -1);
    check("dut0 level when full", fifo_level[0], DEPTH);
    check("dut0 tx still low after pushes", tx[0], 0);
    e_edge = cyc + 1;
    break_req[0] = 1'b0;
    e = q0.pop_front();
    e.start_cyc = e_edge + CLK_DIV;
    e.gap       = CLK_DIV;
    q0.push_front(e);
    wait_drain(0, DEPTH * FRAME0 + 40);

    // Push and pop on the same edge at level 5.
    n0 = cyc + 1;
    push(0, 8'h11, 1'b0, 1'b1, cyc + 2, -1, -1);
    @(negedge clk);
    push(0, 8'h12, 1'b0, 1'b1, n0 + 1 + FRAME0, 0, -1);
    for (int i = 0; i < 4; i++) push(0, 8'(8'h13 + i), 1'b0, 1'b1, -1, 0, -1);
    while (cyc < n0 + FRAME0) @(negedge clk);
    check("dut0 level before push+pop", fifo_level[0], 5);
    push(0, 8'h17, 1'b0, 1'b1, -1, 0, -1);
    check("dut0 level after push+pop", fifo_level[0], 5);
    wait_drain(0, 7 * FRAME0 + 20);

    // Reset during data bit 3 with one more word queued: both are discarded.
    n0 = cyc + 1;
    push(0, 8'h5A, 1'b0, 1'b1, -1, -1, -1);
    push(0, 8'h66, 1'b0, 1'b1, -1, -1, -1);
    while (cyc < n0 + 1 + CLK_DIV * 4 + 1) @(negedge clk);
    #1;
    rst_n = 1'b0;
    q0.delete();
    #1;
    check("dut0 mid-frame reset tx", tx[0], 1);
    check("dut0 mid-frame reset tx_busy", tx_busy[0], 0);
    check("dut0 mid-frame reset level", fifo_level[0], 0);
    check("dut0 mid-frame reset frame_done", frame_done[0], 0);
    check("dut0 mid-frame reset s_ready", s_ready[0], 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (FRAME0 + 20) begin
      @(negedge clk);
      pulses += int'(frame_done[0]);
    end
    check("dut0 frame_done pulses after reset", pulses, 0);
    push(0, 8'h3C, 1'b0, 1'b1, cyc + 2, -1, 0);
    wait_drain(0, FRAME0 + 20);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
